// File: rtl/mem_pkg.sv
// Shared types for the multi-channel memory responder: per-channel state and access op.
package mem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StResp
    } ch_state_e;

    typedef enum logic {
        OpRead,
        OpWrite
    } op_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts at the pointer, and the pointer moves past each winner.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IdxW-1:0]    grant_idx_o
);

    logic [IdxW-1:0] ptr_q;

    always_comb begin
        logic        found;
        int unsigned idx;
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        idx         = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = (32'(ptr_q) + off) % NUM_REQ;
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = IdxW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else if (advance_i && (|req_i)) begin
            ptr_q <= (grant_idx_o == IdxW'(NUM_REQ - 1)) ? '0 : grant_idx_o + 1'b1;
        end
    end

endmodule

// File: rtl/mem_channel_responder.sv
// Memory-side responder: per-channel request FSMs sharing one single-ported array
// through a round-robin arbiter, with a programmable grant-to-ready latency.
module mem_channel_responder
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_BITS    = 8,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned LATENCY      = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CHANNELS-1:0] mem_read_valid,
    input  logic [ADDR_BITS-1:0]    mem_read_address [NUM_CHANNELS],
    output logic [NUM_CHANNELS-1:0] mem_read_ready,
    output logic [DATA_BITS-1:0]    mem_read_data [NUM_CHANNELS],
    input  logic [NUM_CHANNELS-1:0] mem_write_valid,
    input  logic [ADDR_BITS-1:0]    mem_write_address [NUM_CHANNELS],
    input  logic [DATA_BITS-1:0]    mem_write_data [NUM_CHANNELS],
    output logic [NUM_CHANNELS-1:0] mem_write_ready
);

    localparam int unsigned IdxW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int unsigned CntW = $clog2(LATENCY + 1);

    logic [NUM_CHANNELS-1:0] req;
    logic [NUM_CHANNELS-1:0] grant;
    logic [IdxW-1:0]         g_idx;
    op_e                     ch_op    [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]    ch_addr  [NUM_CHANNELS];
    logic [DATA_BITS-1:0]    ch_wdata [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]    g_addr;
    logic [DATA_BITS-1:0]    mem_rd;
    logic [DATA_BITS-1:0]    mem_q [2**ADDR_BITS];

    rr_arbiter #(
        .NUM_REQ (NUM_CHANNELS)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req),
        .advance_i   (1'b1),
        .grant_o     (grant),
        .grant_idx_o (g_idx)
    );

    assign g_addr = ch_addr[g_idx];
    assign mem_rd = mem_q[g_addr];

    // Array is deliberately not reset; contents survive reset assertion.
    always_ff @(posedge clk) begin
        if (reset && (|req) && (ch_op[g_idx] == OpWrite)) begin
            mem_q[g_addr] <= ch_wdata[g_idx];
        end
    end

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        ch_state_e            state_q, state_d;
        op_e                  op_q, op_d, cur_op;
        logic [ADDR_BITS-1:0] addr_q, addr_d, cur_addr;
        logic [DATA_BITS-1:0] wdata_q, wdata_d, cur_wdata;
        logic [DATA_BITS-1:0] rdata_q, rdata_d;
        logic [CntW-1:0]      cnt_q, cnt_d;
        logic                 op_valid;

        // In IDLE the request is taken straight from the inputs so grant can land this cycle.
        always_comb begin
            if (state_q == StIdle) begin
                cur_op    = mem_read_valid[c] ? OpRead : OpWrite;
                cur_addr  = mem_read_valid[c] ? mem_read_address[c] : mem_write_address[c];
                cur_wdata = mem_write_data[c];
            end else begin
                cur_op    = op_q;
                cur_addr  = addr_q;
                cur_wdata = wdata_q;
            end
            op_valid = (cur_op == OpRead) ? mem_read_valid[c] : mem_write_valid[c];
        end

        assign req[c]      = ((state_q == StIdle) || (state_q == StReq)) && op_valid;
        assign ch_op[c]    = cur_op;
        assign ch_addr[c]  = cur_addr;
        assign ch_wdata[c] = cur_wdata;

        always_comb begin
            state_d = state_q;
            op_d    = op_q;
            addr_d  = addr_q;
            wdata_d = wdata_q;
            cnt_d   = cnt_q;
            rdata_d = rdata_q;
            case (state_q)
                StIdle, StReq: begin
                    if (state_q == StIdle && op_valid) begin
                        op_d    = cur_op;
                        addr_d  = cur_addr;
                        wdata_d = cur_wdata;
                    end
                    if (!op_valid) begin
                        state_d = StIdle;
                    end else if (grant[c]) begin
                        cnt_d   = CntW'(LATENCY - 1);
                        state_d = (LATENCY == 1) ? StResp : StWait;
                        if (cur_op == OpRead) rdata_d = mem_rd;
                    end else begin
                        state_d = StReq;
                    end
                end
                StWait: begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CntW'(1)) state_d = StResp;
                end
                StResp: begin
                    if (!op_valid) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= StIdle;
                op_q    <= OpRead;
                addr_q  <= '0;
                wdata_q <= '0;
                cnt_q   <= '0;
                rdata_q <= '0;
            end else begin
                state_q <= state_d;
                op_q    <= op_d;
                addr_q  <= addr_d;
                wdata_q <= wdata_d;
                cnt_q   <= cnt_d;
                rdata_q <= rdata_d;
            end
        end

        assign mem_read_ready[c]  = (state_q == StResp) && (op_q == OpRead);
        assign mem_write_ready[c] = (state_q == StResp) && (op_q == OpWrite);
        assign mem_read_data[c]   = rdata_q;
    end

endmodule

// File: tb/tb_mem_channel_responder.sv
// Self-checking bench for mem_channel_responder: directed scenarios plus randomized batches
// checked against a word-array reference model and spec-derived latency bounds.
module tb_mem_channel_responder;

    localparam int unsigned AW  = 8;
    localparam int unsigned DW  = 8;
    localparam int unsigned NCH = 4;
    localparam int unsigned LAT = 2;

    logic           clk   = 1'b0;
    logic           reset = 1'b0;
    logic [NCH-1:0] rv, wv, rrdy, wrdy;
    logic [AW-1:0]  raddr [NCH];
    logic [AW-1:0]  waddr [NCH];
    logic [DW-1:0]  wdata [NCH];
    logic [DW-1:0]  rdata [NCH];

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DW-1:0] ref_mem [2**AW];
    logic [AW-1:0] known_q [$];

    mem_channel_responder #(
        .ADDR_BITS    (AW),
        .DATA_BITS    (DW),
        .NUM_CHANNELS (NCH),
        .LATENCY      (LAT)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .mem_read_valid    (rv),
        .mem_read_address  (raddr),
        .mem_read_ready    (rrdy),
        .mem_read_data     (rdata),
        .mem_write_valid   (wv),
        .mem_write_address (waddr),
        .mem_write_data    (wdata),
        .mem_write_ready   (wrdy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        rv = '0;
        wv = '0;
        for (int i = 0; i < NCH; i++) begin
            raddr[i] = '0;
            waddr[i] = '0;
            wdata[i] = '0;
        end
    endtask

    task automatic pulse_reset;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    // Cycles from the current cycle (cycle 0) until the ready is seen; -1 on timeout.
    task automatic wait_ready(input int ch, input bit is_rd, output int cyc);
        cyc = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if ((is_rd ? rrdy[ch] : wrdy[ch]) === 1'b1) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ref_mem[a] = d;
        known_q.push_back(a);
    endtask

    task automatic test_reset;
        n_cmp++;
        if (rrdy !== '0) begin
            n_fail++;
            $display("FAIL reset_read_ready: got %b want 0000", rrdy);
        end
        n_cmp++;
        if (wrdy !== '0) begin
            n_fail++;
            $display("FAIL reset_write_ready: got %b want 0000", wrdy);
        end
        for (int c = 0; c < NCH; c++) begin
            n_cmp++;
            if (rdata[c] !== '0) begin
                n_fail++;
                $display("FAIL reset_read_data ch%0d: got %h want 00", c, rdata[c]);
            end
        end
    endtask

    task automatic test_write_read;
        int cyc;
        wv[0] = 1'b1; waddr[0] = 8'h10; wdata[0] = 8'h5A;
        wait_ready(0, 1'b0, cyc);
        n_cmp++;
        if (cyc !== LAT) begin
            n_fail++;
            $display("FAIL wr_latency: got %0d want %0d", cyc, LAT);
        end
        wv[0] = 1'b0;
        tick();
        n_cmp++;
        if (wrdy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_ready_clear: got %b want 0", wrdy[0]);
        end
        model_write(8'h10, 8'h5A);
        rv[0] = 1'b1; raddr[0] = 8'h10;
        wait_ready(0, 1'b1, cyc);
        n_cmp++;
        if (cyc !== LAT) begin
            n_fail++;
            $display("FAIL rd_latency: got %0d want %0d", cyc, LAT);
        end
        n_cmp++;
        if (rdata[0] !== ref_mem[8'h10]) begin
            n_fail++;
            $display("FAIL rd_data: got %h want %h", rdata[0], ref_mem[8'h10]);
        end
        rv[0] = 1'b0;
        tick();
    endtask

    task automatic test_contention;
        int first [NCH];
        pulse_reset();
        for (int c = 0; c < NCH; c++) begin
            first[c] = -1;
            rv[c]    = 1'b1;
            raddr[c] = 8'h10;
        end
        for (int k = 1; k <= 12; k++) begin
            tick();
            for (int c = 0; c < NCH; c++) if (rrdy[c] === 1'b1 && first[c] < 0) first[c] = k;
        end
        for (int c = 0; c < NCH; c++) begin
            n_cmp++;
            if (first[c] !== int'(LAT) + c) begin
                n_fail++;
                $display("FAIL contention_ready ch%0d: got cycle %0d want %0d", c, first[c],
                         int'(LAT) + c);
            end
            n_cmp++;
            if (rdata[c] !== ref_mem[8'h10]) begin
                n_fail++;
                $display("FAIL contention_data ch%0d: got %h want %h", c, rdata[c],
                         ref_mem[8'h10]);
            end
        end
        rv = '0;
        tick();
        tick();
    endtask

    task automatic test_race;
        int            cyc;
        int            f1, f2;
        logic [DW-1:0] exp_old;
        pulse_reset();
        // A single ch0 grant leaves the pointer at 1.
        wv[0] = 1'b1; waddr[0] = 8'h20; wdata[0] = 8'h11;
        wait_ready(0, 1'b0, cyc);
        wv[0] = 1'b0;
        tick();
        model_write(8'h20, 8'h11);
        exp_old = ref_mem[8'h20];
        wv[2] = 1'b1; waddr[2] = 8'h20; wdata[2] = 8'hAA;
        rv[1] = 1'b1; raddr[1] = 8'h20;
        f1 = -1;
        f2 = -1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (rrdy[1] === 1'b1 && f1 < 0) f1 = k;
            if (wrdy[2] === 1'b1 && f2 < 0) f2 = k;
        end
        n_cmp++;
        if (f1 !== int'(LAT) || f2 !== int'(LAT) + 1) begin
            n_fail++;
            $display("FAIL race_order: got ch1=%0d ch2=%0d want %0d %0d", f1, f2, LAT, LAT + 1);
        end
        n_cmp++;
        if (rdata[1] !== exp_old) begin
            n_fail++;
            $display("FAIL race_old_data: got %h want %h", rdata[1], exp_old);
        end
        rv[1] = 1'b0;
        wv[2] = 1'b0;
        tick();
        model_write(8'h20, 8'hAA);
        rv[1] = 1'b1; raddr[1] = 8'h20;
        wait_ready(1, 1'b1, cyc);
        n_cmp++;
        if (cyc !== LAT || rdata[1] !== ref_mem[8'h20]) begin
            n_fail++;
            $display("FAIL race_new_data: got %h at %0d want %h at %0d", rdata[1], cyc,
                     ref_mem[8'h20], LAT);
        end
        rv[1] = 1'b0;
        tick();
    endtask

    task automatic test_ready_hold;
        int cyc;
        rv[0] = 1'b1; raddr[0] = 8'h10;
        wait_ready(0, 1'b1, cyc);
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++;
            if (rrdy[0] !== 1'b1 || rdata[0] !== ref_mem[8'h10]) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: got rdy=%b data=%h want 1 %h", k, rrdy[0],
                         rdata[0], ref_mem[8'h10]);
            end
        end
        rv[0] = 1'b0;
        #1;
        n_cmp++;
        if (rrdy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_before_edge: got %b want 1", rrdy[0]);
        end
        tick();
        n_cmp++;
        if (rrdy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_clear: got %b want 0", rrdy[0]);
        end
        rv[0] = 1'b1; raddr[0] = 8'h20;
        wait_ready(0, 1'b1, cyc);
        n_cmp++;
        if (cyc !== LAT || rdata[0] !== ref_mem[8'h20]) begin
            n_fail++;
            $display("FAIL hold_next_req: got %h at %0d want %h at %0d", rdata[0], cyc,
                     ref_mem[8'h20], LAT);
        end
        rv[0] = 1'b0;
        tick();
    endtask

    task automatic test_both_valids;
        int cyc;
        rv[3] = 1'b1; raddr[3] = 8'h10;
        wv[3] = 1'b1; waddr[3] = 8'h10; wdata[3] = 8'h77;
        wait_ready(3, 1'b1, cyc);
        n_cmp++;
        if (cyc !== LAT || rdata[3] !== ref_mem[8'h10] || wrdy[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL both_read_first: got %h at %0d wrdy=%b want %h at %0d wrdy=0",
                     rdata[3], cyc, wrdy[3], ref_mem[8'h10], LAT);
        end
        rv[3] = 1'b0;
        wait_ready(3, 1'b0, cyc);
        n_cmp++;
        if (cyc !== LAT + 1) begin
            n_fail++;
            $display("FAIL both_write_after: got %0d want %0d", cyc, LAT + 1);
        end
        wv[3] = 1'b0;
        tick();
        model_write(8'h10, 8'h77);
        rv[3] = 1'b1; raddr[3] = 8'h10;
        wait_ready(3, 1'b1, cyc);
        n_cmp++;
        if (rdata[3] !== ref_mem[8'h10]) begin
            n_fail++;
            $display("FAIL both_write_data: got %h want %h", rdata[3], ref_mem[8'h10]);
        end
        rv[3] = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid;
        int cyc;
        rv[1] = 1'b1; raddr[1] = 8'h10;
        tick();
        tick();
        wv[0] = 1'b1; waddr[0] = 8'h40; wdata[0] = 8'h33;
        tick();
        n_cmp++;
        if (rrdy[1] !== 1'b1 || wrdy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_pre: got rrdy1=%b wrdy0=%b want 1 0", rrdy[1], wrdy[0]);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (rrdy !== '0 || wrdy !== '0) begin
            n_fail++;
            $display("FAIL rstmid_ready: got r=%b w=%b want 0000 0000", rrdy, wrdy);
        end
        n_cmp++;
        if (rdata[1] !== '0) begin
            n_fail++;
            $display("FAIL rstmid_data: got %h want 00", rdata[1]);
        end
        clear_inputs();
        model_write(8'h40, 8'h33);
        @(negedge clk);
        reset = 1'b1;
        tick();
        rv[0] = 1'b1; raddr[0] = 8'h40;
        wait_ready(0, 1'b1, cyc);
        n_cmp++;
        if (cyc !== LAT || rdata[0] !== ref_mem[8'h40]) begin
            n_fail++;
            $display("FAIL rstmid_readback: got %h at %0d want %h at %0d", rdata[0], cyc,
                     ref_mem[8'h40], LAT);
        end
        rv[0] = 1'b0;
        tick();
    endtask

    task automatic test_random;
        for (int b = 0; b < 16; b++) begin
            logic [NCH-1:0] act;
            logic [NCH-1:0] is_wr;
            logic [DW-1:0]  exp_d [NCH];
            int             first [NCH];
            act   = NCH'($urandom_range(1, (1 << NCH) - 1));
            is_wr = NCH'($urandom);
            for (int c = 0; c < NCH; c++) begin
                first[c] = -1;
                exp_d[c] = '0;
                if (act[c]) begin
                    if (is_wr[c]) begin
                        wv[c]    = 1'b1;
                        waddr[c] = AW'(8'h80 + b * 4 + c);
                        wdata[c] = DW'($urandom);
                    end else begin
                        rv[c]    = 1'b1;
                        raddr[c] = known_q[$urandom_range(0, known_q.size() - 1)];
                        exp_d[c] = ref_mem[raddr[c]];
                    end
                end
            end
            for (int k = 1; k <= 12; k++) begin
                tick();
                for (int c = 0; c < NCH; c++) begin
                    if ((rrdy[c] === 1'b1 || wrdy[c] === 1'b1) && first[c] < 0) first[c] = k;
                end
            end
            for (int c = 0; c < NCH; c++) begin
                n_cmp++;
                if (!act[c]) begin
                    if (first[c] != -1) begin
                        n_fail++;
                        $display("FAIL rnd%0d_idle ch%0d: got ready at %0d want none", b, c,
                                 first[c]);
                    end
                end else if (first[c] < int'(LAT) || first[c] > int'(LAT + NCH - 1)) begin
                    n_fail++;
                    $display("FAIL rnd%0d_latency ch%0d: got %0d want %0d..%0d", b, c,
                             first[c], LAT, LAT + NCH - 1);
                end else if (!is_wr[c] && (rdata[c] !== exp_d[c] || rrdy[c] !== 1'b1)) begin
                    n_fail++;
                    $display("FAIL rnd%0d_data ch%0d: got %h rdy=%b want %h rdy=1", b, c,
                             rdata[c], rrdy[c], exp_d[c]);
                end
            end
            rv = '0;
            wv = '0;
            tick();
            tick();
            for (int c = 0; c < NCH; c++) if (act[c] && is_wr[c]) model_write(waddr[c], wdata[c]);
        end
    endtask

    initial begin
        clear_inputs();
        #12;
        test_reset();
        @(negedge clk);
        reset = 1'b1;
        tick();
        test_write_read();
        test_contention();
        test_race();
        test_ready_hold();
        test_both_valids();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
